// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the arbitrated data-memory bus.
// Word-addressed SRAM with fixed read/write response latency. Each accepted
// request produces exactly one registered DataMem_Ready pulse.
// Ports:
//   clock, reset            single clock, synchronous active-low reset
//   DataMem_Read            read request
//   DataMem_Write[3:0]      byte write enables (a request when any bit is set)
//   DataMem_Address[29:0]   word address
//   DataMem_Out[31:0]       write data from master
//   DataMem_In[31:0]        read data to master, held until next completed read
//   DataMem_Ready           one-cycle completion pulse
//   DataMem_AddrErr         pulses with Ready when address is beyond the array
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DataMem_Read,
    input  logic [3:0]  DataMem_Write,
    input  logic [29:0] DataMem_Address,
    input  logic [31:0] DataMem_Out,
    output logic [31:0] DataMem_In,
    output logic        DataMem_Ready,
    output logic        DataMem_AddrErr
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [3:0]         be_q, be_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH];

    logic               request_c;
    logic               in_range_c;
    logic               commit_c;
    logic [CNT_W-1:0]   load_c;
    logic [ADDR_WIDTH-1:0] idx_c;

    assign request_c  = DataMem_Read | (|DataMem_Write);
    assign in_range_c = (addr_q[29:ADDR_WIDTH] == '0);
    assign idx_c      = addr_q[ADDR_WIDTH-1:0];
    // Write wins over read when both are requested.
    assign load_c     = (|DataMem_Write) ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
    // The DONE-state edge is the one that raises Ready; reset at that edge aborts the write.
    assign commit_c   = reset && (state_q == S_DONE) && (|be_q) && in_range_c;

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Byte-masked write commit; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (commit_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Next-state and output logic. DONE is the last cycle before the completion edge,
    // so the FSM is back in IDLE while Ready is high and can accept the next request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (request_c) begin
                    rd_d    = DataMem_Read;
                    be_d    = DataMem_Write;
                    addr_d  = DataMem_Address;
                    wdata_d = DataMem_Out;
                    cnt_d   = load_c;
                    state_d = (load_c == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                err_d   = ~in_range_c;
                if (rd_q && (be_q == '0)) begin
                    rdata_d = in_range_c ? mem[idx_c] : 32'h0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign DataMem_In      = rdata_q;
    assign DataMem_Ready   = ready_q;
    assign DataMem_AddrErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder, checked against a
// word-array reference model of the memory and the latency/range rules.
module tb_data_mem_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned RL = 2;
    localparam int unsigned WL = 1;

    logic        clock;
    logic        reset;
    logic        rd_s;
    logic [3:0]  be_s;
    logic [29:0] addr_s;
    logic [31:0] wd_s;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        DataMem_AddrErr;

    int          checks;
    int          errors;
    logic [31:0] mdl [1024];
    logic [31:0] exp_in;

    data_mem_responder #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .DataMem_Read   (rd_s),
        .DataMem_Write  (be_s),
        .DataMem_Address(addr_s),
        .DataMem_Out    (wd_s),
        .DataMem_In     (DataMem_In),
        .DataMem_Ready  (DataMem_Ready),
        .DataMem_AddrErr(DataMem_AddrErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive for one accepting edge, wait for Ready, update model, check.
    task automatic do_txn(input logic rd, input logic [3:0] be, input logic [29:0] addr,
                          input logic [31:0] wd, input string tag);
        int   n;
        int   exp_lat;
        logic inr;
        inr     = (addr[29:AW] == '0);
        exp_lat = int'((be != 4'h0) ? WL : RL) + 1;
        @(negedge clock);
        rd_s = rd; be_s = be; addr_s = addr; wd_s = wd;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) begin
                rd_s = 1'b0; be_s = 4'h0;
            end
        end while (!DataMem_Ready && n < 20);
        if (be != 4'h0) begin
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[addr[AW-1:0]][8*i +: 8] = wd[8*i +: 8];
                end
            end
        end else begin
            exp_in = inr ? mdl[addr[AW-1:0]] : 32'h0;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_addrerr"}, 32'(DataMem_AddrErr), 32'(!inr));
        chk({tag, "_rdata"}, DataMem_In, exp_in);
        @(negedge clock);
        chk({tag, "_pulse_end"}, 32'(DataMem_Ready), 32'h0);
    endtask

    initial begin
        checks = 0; errors = 0; exp_in = 32'h0;
        reset = 1'b0; rd_s = 1'b0; be_s = 4'h0; addr_s = '0; wd_s = '0;

        // Reset state and idle behaviour.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(DataMem_Ready), 32'h0);
        chk("rst_in", DataMem_In, 32'h0);
        chk("rst_err", 32'(DataMem_AddrErr), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_ready", 32'(DataMem_Ready), 32'h0);
        end

        // Give the locations used below known contents.
        for (int a = 0; a < 16; a++) begin
            do_txn(1'b0, 4'hF, 30'(a), $urandom, "init");
        end

        // Full write then read back; then partial byte write.
        do_txn(1'b0, 4'hF, 30'd5, 32'h1234_5678, "wr5");
        do_txn(1'b1, 4'h0, 30'd5, 32'h0, "rd5");
        chk("rd5_const", DataMem_In, 32'h1234_5678);
        do_txn(1'b0, 4'b0101, 30'd5, 32'hAABB_CCDD, "wr5_part");
        do_txn(1'b1, 4'h0, 30'd5, 32'h0, "rd5_part");
        chk("rd5_part_const", DataMem_In, 32'h12BB_56DD);

        // Out-of-range read and write; aliased word 0 must stay untouched.
        do_txn(1'b1, 4'h0, 30'h0000_0400, 32'h0, "rd_oor");
        do_txn(1'b0, 4'hF, 30'h0000_0400, 32'hDEAD_BEEF, "wr_oor");
        do_txn(1'b1, 4'h0, 30'd0, 32'h0, "rd0");

        // Read held high: a pulse every RL+1 cycles with stable data.
        do_txn(1'b1, 4'h0, 30'd5, 32'h0, "rd5_pre");
        @(negedge clock);
        rd_s = 1'b1; addr_s = 30'd5;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clock);
            @(negedge clock);
            chk("held_ready", 32'(DataMem_Ready), 32'((n % (RL + 1)) == 0));
            chk("held_in", DataMem_In, exp_in);
        end
        rd_s = 1'b0;
        @(negedge clock);

        // Read+Write together behaves as a write.
        do_txn(1'b1, 4'hF, 30'd5, 32'hCAFE_F00D, "rdwr");
        do_txn(1'b1, 4'h0, 30'd5, 32'h0, "rd_after_rdwr");

        // Reset one edge after acceptance aborts the write.
        @(negedge clock);
        be_s = 4'hF; addr_s = 30'd5; wd_s = 32'h0BAD_0BAD;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; be_s = 4'h0;
        @(posedge clock);
        @(negedge clock);
        chk("abort_ready", 32'(DataMem_Ready), 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("abort_ready2", 32'(DataMem_Ready), 32'h0);
        exp_in = 32'h0;
        chk("abort_in", DataMem_In, exp_in);
        reset = 1'b1;
        do_txn(1'b1, 4'h0, 30'd5, 32'h0, "rd_after_abort");

        // Randomized traffic over the initialized words plus out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            logic        rd;
            logic [3:0]  be;
            logic [29:0] addr;
            rd = 1'($urandom % 2);
            be = 4'($urandom % 16);
            if (($urandom % 2) == 0) be = 4'h0;
            if (!rd && be == 4'h0) rd = 1'b1;
            if (($urandom % 8) == 0)
                addr = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom % 16)};
            else
                addr = 30'($urandom % 16);
            do_txn(rd, be, addr, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
